csr_regfile: RTL

- Control/status register file for the LoongArch pipeline.
- Consumes the exception, ertn and CSR-write outputs of the writeback stage.
- Serves combinational CSR reads to the execute stage.
- Provides exception entry and return targets, plus a pending-interrupt indication, to fetch and decode.
- Includes a countdown timer that raises timer interrupt IS[11].

---
 rtl/csr_regfile_pkg.sv | 96 +++++++++
 rtl/csr_timer.sv | 95 +++++++++
 rtl/csr_regfile.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_pkg.sv
// ============================================================================
//  Module      : csr_regfile_pkg
//  Description : Shared definitions for the LoongArch CSR register file:
//                CSR addresses, exception codes/subcodes, field bit positions,
//                per-register software-writable masks and a masked-write helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_regfile_pkg;

    // ------------------------------------------------------------------
    // CSR address map
    // ------------------------------------------------------------------
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int unsigned NUM_SAVE   = 4;

    // ------------------------------------------------------------------
    // Exception codes and subcodes
    // ------------------------------------------------------------------
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_FPD  = 6'h0F;
    localparam logic [5:0] ECODE_FPE  = 6'h12;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    // ------------------------------------------------------------------
    // Field bit positions
    // ------------------------------------------------------------------
    localparam int unsigned CRMD_PLV_LSB     = 0;
    localparam int unsigned CRMD_PLV_MSB     = 1;
    localparam int unsigned CRMD_IE          = 2;
    localparam int unsigned CRMD_DA          = 3;
    localparam int unsigned PRMD_PPLV_LSB    = 0;
    localparam int unsigned PRMD_PPLV_MSB    = 1;
    localparam int unsigned PRMD_PIE         = 2;
    localparam int unsigned ESTAT_IS_MSB     = 12;
    localparam int unsigned ESTAT_ECODE_LSB  = 16;
    localparam int unsigned ESTAT_ECODE_MSB  = 21;
    localparam int unsigned ESTAT_ESUB_LSB   = 22;
    localparam int unsigned ESTAT_ESUB_MSB   = 30;
    localparam int unsigned TCFG_EN          = 0;
    localparam int unsigned TCFG_PERIODIC    = 1;
    localparam int unsigned TICLR_CLR        = 0;

    // ------------------------------------------------------------------
    // Reset values and software-writable masks
    // ------------------------------------------------------------------
    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

    // Merge a software write into a register, touching only writable bits.
    function automatic logic [31:0] csr_mask_write(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [31:0] wmask
    );
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_timer.sv
// ============================================================================
//  Module      : csr_timer
//  Description : Countdown timer behind TCFG/TVAL/TICLR. Holds TCFG, the
//                TVAL counter, the armed flag and the timer interrupt TI.
//  Ports       : clk, resetn        - clock, async active-low reset
//                tcfg_we_i          - software write strobe to TCFG
//                wvalue_i           - software write data
//                ticlr_i            - TICLR write with bit0 set (clear TI)
//                tcfg_o             - current TCFG value
//                tval_o             - current TVAL counter
//                ti_o               - timer interrupt flag (ESTAT.IS[11])
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_timer
    import csr_regfile_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tcfg_we_i,
    input  logic [31:0]        wvalue_i,
    input  logic               ticlr_i,
    output logic [31:0]        tcfg_o,
    output logic [TIMER_W-1:0] tval_o,
    output logic               ti_o
);

    logic [31:0]        tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               armed_q, armed_d;
    logic               ti_q, ti_d;
    logic [TIMER_W-1:0] w_reload;
    logic [TIMER_W-1:0] w_wr_reload;

    // InitVal occupies TCFG[TIMER_W-1:2]; the counter is loaded with InitVal<<2.
    assign w_reload    = {tcfg_q[TIMER_W-1:2], 2'b00};
    assign w_wr_reload = {wvalue_i[TIMER_W-1:2], 2'b00};

    always_comb begin
        tcfg_d  = tcfg_q;
        tval_d  = tval_q;
        armed_d = armed_q;
        ti_d    = ti_q;

        // Clear first so that an expiry in the same cycle overrides it.
        if (ticlr_i) begin
            ti_d = 1'b0;
        end

        if (armed_q && tcfg_q[TCFG_EN]) begin
            if (tval_q != '0) begin
                tval_d = tval_q - {{(TIMER_W-1){1'b0}}, 1'b1};
            end else begin
                ti_d = 1'b1;
                if (tcfg_q[TCFG_PERIODIC]) begin
                    tval_d = w_reload;
                end else begin
                    tval_d  = '1;
                    armed_d = 1'b0;
                end
            end
        end

        // A software TCFG write restarts the counter from the new InitVal.
        if (tcfg_we_i) begin
            tcfg_d  = wvalue_i;
            armed_d = wvalue_i[TCFG_EN];
            tval_d  = w_wr_reload;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_q  <= '0;
            tval_q  <= '0;
            armed_q <= 1'b0;
            ti_q    <= 1'b0;
        end else begin
            tcfg_q  <= tcfg_d;
            tval_q  <= tval_d;
            armed_q <= armed_d;
            ti_q    <= ti_d;
        end
    end

    assign tcfg_o = tcfg_q;
    assign tval_o = tval_q;
    assign ti_o   = ti_q;

endmodule

`default_nettype wire

// File: rtl/csr_regfile.sv
// ============================================================================
//  Module      : csr_regfile
//  Description : LoongArch control/status register file. Takes exception,
//                ertn and CSR-write commits from writeback, serves
//                combinational CSR reads, and provides exception entry/return
//                targets and a pending-interrupt flag.
//  Config      : `CSR_TIMER_EN - when defined, TID/TCFG/TVAL/TICLR and the
//                countdown timer (csr_timer) are present; otherwise those
//                addresses are unmapped and IS[11] is tied to 0.
//  Ports       : clk, resetn                  - clock, async active-low reset
//                csr_rnum / csr_rvalue        - combinational read port
//                csr_we/csr_num/csr_wvalue    - software write from WB
//                excp_flush / ertn_flush      - exception / ertn commit
//                wb_ecode/wb_esubcode/wb_pc   - exception information
//                hw_int                       - level hardware interrupts
//                ex_entry / era_entry         - EENTRY / ERA values
//                has_int                      - enabled interrupt pending
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int TIMER_W  = 32,
    parameter int HW_INT_W = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [13:0]         csr_rnum,
    output logic [31:0]         csr_rvalue,
    input  logic                csr_we,
    input  logic [13:0]         csr_num,
    input  logic [31:0]         csr_wvalue,
    input  logic                excp_flush,
    input  logic                ertn_flush,
    input  logic [5:0]          wb_ecode,
    input  logic [8:0]          wb_esubcode,
    input  logic [31:0]         wb_pc,
    input  logic [HW_INT_W-1:0] hw_int,
    output logic [31:0]         ex_entry,
    output logic [31:0]         era_entry,
    output logic                has_int
);

    typedef logic [TIMER_W-1:0] tval_t;

    logic [31:0]         crmd_q,   crmd_d;
    logic [31:0]         prmd_q,   prmd_d;
    logic [31:0]         ecfg_q,   ecfg_d;
    logic [31:0]         era_q,    era_d;
    logic [31:0]         badv_q,   badv_d;
    logic [31:0]         eentry_q, eentry_d;
    logic [31:0]         save_q [NUM_SAVE];
    logic [31:0]         save_d [NUM_SAVE];
    logic [1:0]          is_sw_q,  is_sw_d;
    logic [HW_INT_W-1:0] is_hw_q;
    logic [5:0]          ecode_q,  ecode_d;
    logic [8:0]          esub_q,   esub_d;

    logic                w_ti;
    logic [7:0]          w_hw8;
    logic [12:0]         w_is;
    logic [31:0]         w_estat;

    // ------------------------------------------------------------------
    // Next-state for architectural registers
    // ------------------------------------------------------------------
    // Software writes are applied first; the exception/ertn updates below
    // then override the fields they own, so hardware wins on a collision
    // while writes to unrelated fields/CSRs in the same cycle still land.
    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        is_sw_d  = is_sw_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        for (int i = 0; i < NUM_SAVE; i++) begin
            save_d[i] = save_q[i];
        end

        if (csr_we) begin
            unique case (csr_num)
                CSR_CRMD:   crmd_d   = csr_mask_write(crmd_q, csr_wvalue, CRMD_WMASK);
                CSR_PRMD:   prmd_d   = csr_mask_write(prmd_q, csr_wvalue, PRMD_WMASK);
                CSR_ECFG:   ecfg_d   = csr_mask_write(ecfg_q, csr_wvalue, ECFG_WMASK);
                CSR_ESTAT:  is_sw_d  = csr_wvalue[1:0];
                CSR_ERA:    era_d    = csr_wvalue;
                CSR_BADV:   badv_d   = csr_wvalue;
                CSR_EENTRY: eentry_d = csr_mask_write(eentry_q, csr_wvalue, EENTRY_WMASK);
                CSR_SAVE0:  save_d[0] = csr_wvalue;
                CSR_SAVE1:  save_d[1] = csr_wvalue;
                CSR_SAVE2:  save_d[2] = csr_wvalue;
                CSR_SAVE3:  save_d[3] = csr_wvalue;
                default: ;
            endcase
        end

        if (excp_flush) begin
            prmd_d[PRMD_PPLV_MSB:PRMD_PPLV_LSB] = crmd_q[CRMD_PLV_MSB:CRMD_PLV_LSB];
            prmd_d[PRMD_PIE]                    = crmd_q[CRMD_IE];
            crmd_d[CRMD_PLV_MSB:CRMD_PLV_LSB]   = 2'b00;
            crmd_d[CRMD_IE]                     = 1'b0;
            era_d                               = wb_pc;
            ecode_d                             = wb_ecode;
            esub_d                              = wb_esubcode;
        end else if (ertn_flush) begin
            crmd_d[CRMD_PLV_MSB:CRMD_PLV_LSB]   = prmd_q[PRMD_PPLV_MSB:PRMD_PPLV_LSB];
            crmd_d[CRMD_IE]                     = prmd_q[PRMD_PIE];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q   <= CRMD_RESET;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            is_sw_q  <= '0;
            is_hw_q  <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= '0;
            end
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= hw_int;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= save_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Timer (optional)
    // ------------------------------------------------------------------
`ifdef CSR_TIMER_EN
    logic [31:0] tid_q, tid_d;
    logic [31:0] w_tcfg;
    tval_t       w_tval;
    logic        w_tcfg_we;
    logic        w_ticlr;

    assign w_tcfg_we = csr_we && (csr_num == CSR_TCFG);
    assign w_ticlr   = csr_we && (csr_num == CSR_TICLR) && csr_wvalue[TICLR_CLR];
    assign tid_d     = (csr_we && (csr_num == CSR_TID)) ? csr_wvalue : tid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q <= '0;
        end else begin
            tid_q <= tid_d;
        end
    end

    csr_timer #(
        .TIMER_W   (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .tcfg_we_i (w_tcfg_we),
        .wvalue_i  (csr_wvalue),
        .ticlr_i   (w_ticlr),
        .tcfg_o    (w_tcfg),
        .tval_o    (w_tval),
        .ti_o      (w_ti)
    );
`else
    assign w_ti = 1'b0;
`endif

    // ------------------------------------------------------------------
    // ESTAT composition and interrupt detection
    // ------------------------------------------------------------------
    // IS layout: [12] IPI (unused), [11] TI, [10] reserved, [9:2] HWI, [1:0] SWI
    assign w_hw8   = 8'(is_hw_q);
    assign w_is    = {1'b0, w_ti, 1'b0, w_hw8, is_sw_q};
    assign w_estat = {1'b0, esub_q, ecode_q, 3'b000, w_is};

    assign has_int   = crmd_q[CRMD_IE] & (|(w_is & ecfg_q[ESTAT_IS_MSB:0]));
    assign ex_entry  = eentry_q;
    assign era_entry = era_q;

    // ------------------------------------------------------------------
    // Read mux: registered values only, no same-cycle write bypass
    // ------------------------------------------------------------------
    always_comb begin
        csr_rvalue = '0;
        unique case (csr_rnum)
            CSR_CRMD:   csr_rvalue = crmd_q;
            CSR_PRMD:   csr_rvalue = prmd_q;
            CSR_ECFG:   csr_rvalue = ecfg_q;
            CSR_ESTAT:  csr_rvalue = w_estat;
            CSR_ERA:    csr_rvalue = era_q;
            CSR_BADV:   csr_rvalue = badv_q;
            CSR_EENTRY: csr_rvalue = eentry_q;
            CSR_SAVE0:  csr_rvalue = save_q[0];
            CSR_SAVE1:  csr_rvalue = save_q[1];
            CSR_SAVE2:  csr_rvalue = save_q[2];
            CSR_SAVE3:  csr_rvalue = save_q[3];
`ifdef CSR_TIMER_EN
            CSR_TID:    csr_rvalue = tid_q;
            CSR_TCFG:   csr_rvalue = w_tcfg;
            CSR_TVAL:   csr_rvalue = 32'(w_tval);
            CSR_TICLR:  csr_rvalue = '0;
`endif
            default:    csr_rvalue = '0;
        endcase
    end

endmodule

`default_nettype wire
